br_param: RTL and testbench



---
 rtl/br_param.sv | 106 ++++++++++
 tb/tb_br_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/br_param.sv
// br_param: parametrised register bank with a sequenced clear, write range protection and an optional zero entry.
// Define BR_BYPASS_EN to forward same-cycle write data onto matching read ports.
module br_param #(
  parameter int ANCHO   = 32,
  parameter int PROF    = 16,
  parameter int AW      = 5,
  parameter int CERO_R0 = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    RA1,
  input  logic [AW-1:0]    RA2,
  input  logic [AW-1:0]    WA,
  input  logic             WE,
  input  logic [ANCHO-1:0] DW,
  output logic [ANCHO-1:0] DR1,
  output logic [ANCHO-1:0] DR2,
  output logic             LISTO,
  output logic             ERR
);

  localparam int IW = (PROF > 1) ? $clog2(PROF) : 1;
  localparam logic [AW:0]   PROF_W = (AW+1)'(PROF);
  localparam logic [AW-1:0] LAST   = AW'(PROF - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state, stateNext;
  logic [AW-1:0]    cnt, cntNext;
  logic             errNext;
  logic             wrEn;
  logic [IW-1:0]    wrAddr;
  logic [ANCHO-1:0] wrData;
  logic             waInRange, waLegal;
  logic [ANCHO-1:0] mem [PROF];

  function automatic logic inRange(input logic [AW-1:0] a);
    return {1'b0, a} < PROF_W;
  endfunction

  // An address is a real storage target only if it exists and is not the hardwired zero entry.
  function automatic logic usable(input logic [AW-1:0] a);
    return inRange(a) && !((CERO_R0 != 0) && (a == '0));
  endfunction

  assign waInRange = inRange(WA);
  assign waLegal   = usable(WA);
  assign LISTO     = (state == READY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      ERR   <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      ERR   <= errNext;
    end
  end

  // The clear sequencer and the external write port share one array write path.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    errNext   = ERR;
    wrEn      = 1'b0;
    wrAddr    = WA[IW-1:0];
    wrData    = DW;
    case (state)
      CLEAR: begin
        wrEn    = 1'b1;
        wrAddr  = cnt[IW-1:0];
        wrData  = '0;
        cntNext = cnt + 1'b1;
        if (cnt == LAST) stateNext = READY;
      end
      READY: begin
        if (WE) begin
          if (!waInRange) errNext = 1'b1;
          else if (waLegal) wrEn = 1'b1;
        end
      end
      default: stateNext = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && wrEn) mem[wrAddr] <= wrData;
  end

  // Reads are held at zero until the clear sequence has finished.
  always_comb begin
    DR1 = '0;
    DR2 = '0;
    if (state == READY) begin
      if (usable(RA1)) DR1 = mem[RA1[IW-1:0]];
      if (usable(RA2)) DR2 = mem[RA2[IW-1:0]];
`ifdef BR_BYPASS_EN
      if (WE && waLegal && (RA1 == WA)) DR1 = DW;
      if (WE && waLegal && (RA2 == WA)) DR2 = DW;
`endif
    end
  end

endmodule

// File: tb/tb_br_param.sv
// tb_br_param: directed and randomized checks of br_param against a behavioural model.
// Covers the default 32x16 bank with zero entry and a 16x8 bank without it.
module tb_br_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  ra1, ra2, wa;
  logic        we;
  logic [31:0] dw, dr1, dr2;
  logic        listo, err;

  logic        rstB;
  logic [2:0]  ra1B, ra2B, waB;
  logic        weB;
  logic [15:0] dwB, dr1B, dr2B;
  logic        listoB, errB;

  int total = 0;
  int bad = 0;

  br_param dutA (
    .clk(clk), .rst(rst), .RA1(ra1), .RA2(ra2), .WA(wa), .WE(we), .DW(dw),
    .DR1(dr1), .DR2(dr2), .LISTO(listo), .ERR(err)
  );

  br_param #(.ANCHO(16), .PROF(8), .AW(3), .CERO_R0(0)) dutB (
    .clk(clk), .rst(rstB), .RA1(ra1B), .RA2(ra2B), .WA(waB), .WE(weB), .DW(dwB),
    .DR1(dr1B), .DR2(dr2B), .LISTO(listoB), .ERR(errB)
  );

  // Behavioural model: contents, readiness after PROF clean edges, sticky error.
  logic [31:0] mA [16];
  bit          rdyA = 1'b0;
  int          clrA = 0;
  bit          errMA = 1'b0;
  logic [15:0] mB [8];
  bit          rdyB = 1'b0;
  int          clrB = 0;
  bit          errMB = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      rdyA = 1'b0; clrA = 0; errMA = 1'b0;
    end else if (!rdyA) begin
      mA[clrA] = 32'h0;
      clrA++;
      if (clrA == 16) rdyA = 1'b1;
    end else if (we) begin
      if (int'(wa) >= 16) errMA = 1'b1;
      else if (wa != 5'd0) mA[wa[3:0]] = dw;
    end

    if (rstB) begin
      rdyB = 1'b0; clrB = 0; errMB = 1'b0;
    end else if (!rdyB) begin
      mB[clrB] = 16'h0;
      clrB++;
      if (clrB == 8) rdyB = 1'b1;
    end else if (weB) begin
      mB[waB] = dwB;
    end
  end

  function automatic logic [31:0] expA(input logic [4:0] ra);
    if (!rdyA || int'(ra) >= 16 || ra == 5'd0) return 32'h0;
`ifdef BR_BYPASS_EN
    if (we && wa == ra) return dw;
`endif
    return mA[ra[3:0]];
  endfunction

  function automatic logic [15:0] expB(input logic [2:0] ra);
    if (!rdyB) return 16'h0;
`ifdef BR_BYPASS_EN
    if (weB && waB == ra) return dwB;
`endif
    return mB[ra];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] d,
                               input logic [4:0] r1, input logic [4:0] r2);
    we = w; wa = a; dw = d; ra1 = r1; ra2 = r2;
    #1;
  endtask

  task automatic applyStimulusB(input logic w, input logic [2:0] a, input logic [15:0] d,
                                input logic [2:0] r1, input logic [2:0] r2);
    weB = w; waB = a; dwB = d; ra1B = r1; ra2B = r2;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkModelA(input string tag);
    checkOutput({tag, "_dr1"}, dr1, expA(ra1));
    checkOutput({tag, "_dr2"}, dr2, expA(ra2));
    checkOutput({tag, "_listo"}, 32'(listo), 32'(rdyA));
    checkOutput({tag, "_err"}, 32'(err), 32'(errMA));
  endtask

  task automatic checkModelB(input string tag);
    checkOutput({tag, "_dr1"}, 32'(dr1B), 32'(expB(ra1B)));
    checkOutput({tag, "_dr2"}, 32'(dr2B), 32'(expB(ra2B)));
    checkOutput({tag, "_listo"}, 32'(listoB), 32'(rdyB));
    checkOutput({tag, "_err"}, 32'(errB), 32'(errMB));
  endtask

  initial begin
    logic [4:0]  rw, r1, r2;
    logic [2:0]  bw, b1, b2;
    logic [15:0] v;

    rst = 1'b1;
    rstB = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    applyStimulusB(1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    checkOutput("rst_listo", 32'(listo), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_dr1", dr1, 32'h0);

    applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd9);
    for (int i = 1; i <= 16; i++) begin
      if (i < 16) checkOutput("clr_dr1", dr1, 32'h0);
      step();
      checkOutput("clr_listo", 32'(listo), (i == 16) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    checkOutput("clr_err", 32'(err), 32'd0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(15 - i));
      checkOutput("clr_rd1", dr1, 32'h0);
      checkOutput("clr_rd2", dr2, 32'h0);
    end

    applyStimulus(1'b1, 5'd5, 32'h12345678, 5'd0, 5'd0);
    step();
    applyStimulus(1'b1, 5'd15, 32'hFFFFFFFF, 5'd0, 5'd0);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd15);
    checkOutput("wr_dr1", dr1, 32'h12345678);
    checkOutput("wr_dr2", dr2, 32'hFFFFFFFF);

    applyStimulus(1'b1, 5'd0, 32'hAAAA5555, 5'd0, 5'd0);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
    checkOutput("zero_dr1", dr1, 32'h0);
    checkOutput("zero_err", 32'(err), 32'd0);
    checkOutput("zero_dr2", dr2, 32'h12345678);

    applyStimulus(1'b1, 5'd20, 32'h5A5A5A5A, 5'd0, 5'd0);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd20);
    checkOutput("oor_alias", dr1, 32'h0);
    checkOutput("oor_dr2", dr2, 32'h0);
    checkOutput("oor_err", 32'(err), 32'd1);
    step();
    step();
    checkOutput("oor_sticky", 32'(err), 32'd1);

    applyStimulus(1'b1, 5'd7, 32'h11, 5'd0, 5'd0);
    step();
    applyStimulus(1'b1, 5'd7, 32'h0BADF00D, 5'd7, 5'd15);
`ifdef BR_BYPASS_EN
    checkOutput("haz_dr1", dr1, 32'h0BADF00D);
`else
    checkOutput("haz_dr1", dr1, 32'h11);
`endif
    checkOutput("haz_dr2", dr2, 32'hFFFFFFFF);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    checkOutput("haz_after", dr1, 32'h0BADF00D);

    for (int n = 0; n < 300; n++) begin
      rw = 5'($urandom_range(0, 31));
      r1 = (n % 4 == 0) ? rw : 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      applyStimulus(1'($urandom_range(0, 1)), rw, $urandom(), r1, r2);
      checkModelA("rndA");
      step();
    end

    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    for (int i = 1; i <= 16; i++) begin
      step();
      checkOutput("mid_listo", 32'(listo), (i == 16) ? 32'd1 : 32'd0);
    end
    checkOutput("mid_err", 32'(err), 32'd0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(i));
      checkOutput("mid_rd", dr1, 32'h0);
    end

    rstB = 1'b0;
    #1;
    for (int i = 1; i <= 8; i++) begin
      step();
      checkOutput("b_listo", 32'(listoB), (i == 8) ? 32'd1 : 32'd0);
    end
    applyStimulusB(1'b1, 3'd0, 16'hBEEF, 3'd1, 3'd2);
    step();
    applyStimulusB(1'b0, 3'd0, 16'h0, 3'd0, 3'd1);
    checkOutput("b_zero", 32'(dr1B), 32'h0000BEEF);
    checkOutput("b_other", 32'(dr2B), 32'h0);
    for (int i = 0; i < 8; i++) begin
      v = 16'(32'h1111 * i + 32'h0101);
      applyStimulusB(1'b1, 3'(i), v, 3'd0, 3'd0);
      step();
    end
    applyStimulusB(1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulusB(1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i));
      checkOutput("b_rd1", 32'(dr1B), 32'h1111 * i + 32'h0101);
      checkOutput("b_rd2", 32'(dr2B), 32'h1111 * (7 - i) + 32'h0101);
    end
    checkOutput("b_err", 32'(errB), 32'd0);

    for (int n = 0; n < 200; n++) begin
      bw = 3'($urandom_range(0, 7));
      b1 = (n % 4 == 0) ? bw : 3'($urandom_range(0, 7));
      b2 = 3'($urandom_range(0, 7));
      applyStimulusB(1'($urandom_range(0, 1)), bw, 16'($urandom()), b1, b2);
      checkModelB("rndB");
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
